// File: rtl/debug_frame_rx_pkg.sv
// Shared debug-coprocessor definitions.
// Holds the request and reply sync words, the frame geometry, the command
// opcodes, the receiver FSM state encoding and the CRC16-CCITT byte step.
// Any frame that is checked against a reply-path CRC must use crc16_byte,
// so that both directions use the same polynomial and seed.
package debug_frame_rx_pkg;

  localparam int          DBG_DATA_WIDTH   = 8;
  localparam int          DBG_FRAME_LENGTH = 12;
  localparam int          DBG_SYNC_LEN     = 2;
  localparam int          DBG_CRC_LEN      = 2;
  localparam logic [15:0] DBG_REQ_SYNC     = 16'h5AA5;
  localparam logic [15:0] DBG_RPL_SYNC     = 16'hA55A;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [7:0] {
    OP_NOP       = 8'h00,
    OP_READ_MEM  = 8'h01,
    OP_WRITE_MEM = 8'h02,
    OP_READ_REG  = 8'h03,
    OP_WRITE_REG = 8'h04,
    OP_HALT      = 8'h10,
    OP_RESUME    = 8'h11,
    OP_STEP      = 8'h12
  } dbg_opcode_e;

  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_SEED0 = 3'd1,
    S_SEED1 = 3'd2,
    S_BODY  = 3'd3,
    S_CRC   = 3'd4,
    S_CHECK = 3'd5
  } dfr_state_e;

  // One byte of CRC16-CCITT, MSB of the data first, no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/debug_frame_rx_crc.sv
// crc16_CCITT: byte-wide CRC16-CCITT engine shared with the reply path.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (loads the seed)
//   sync_reset   reload the seed on the next edge (wins over crc_en)
//   crc_en       fold data_in into the running CRC on the next edge
//   data_in      byte to fold in
//   crc_out      running CRC register
module crc16_CCITT
  import debug_frame_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync_reset,
  input  logic        crc_en,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_crc <= CRC16_INIT;
    else if (sync_reset) r_crc <= CRC16_INIT;
    else if (crc_en)     r_crc <= crc16_byte(r_crc, data_in);
  end

  assign crc_out = r_crc;

endmodule

// File: rtl/debug_frame_rx.sv
// debug_frame_rx: request-frame receiver for the on-chip-debug path.
// Hunts for the 2-byte sync in the UART byte stream, collects command +
// payload, checks the trailing CRC16-CCITT (coverage: sync + body) and
// strobes the result to the command decoder.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   uart_rx_valid/_data       one-cycle byte strobe and byte from the UART
//   frame_valid               one-cycle strobe, good frame, cmd/payload updated
//   frame_cmd, frame_payload  last good frame, held until the next one
//   crc_error                 one-cycle strobe, complete frame with bad CRC
//   timeout_error             one-cycle strobe, frame dropped on idle timeout
//   busy                      frame in progress (any state but S_HUNT)
//
// state   | meaning
// S_HUNT  | searching for sync, CRC engine held at seed
// S_SEED0 | fold sync high byte into CRC
// S_SEED1 | fold sync low byte into CRC
// S_BODY  | collecting command + payload bytes
// S_CRC   | collecting the two received CRC bytes, MSB first
// S_CHECK | compare CRC, emit outcome strobe, back to hunt
module debug_frame_rx
  import debug_frame_rx_pkg::*;
#(
  parameter int          DATA_WIDTH     = DBG_DATA_WIDTH,
  parameter int          FRAME_LENGTH   = DBG_FRAME_LENGTH,
  parameter int          SYNC_LEN       = DBG_SYNC_LEN,
  parameter int          CRC_LEN        = DBG_CRC_LEN,
  parameter logic [15:0] SYNC_WORD      = DBG_REQ_SYNC,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic                                                   clk,
  input  logic                                                   reset_n,
  input  logic                                                   uart_rx_valid,
  input  logic [DATA_WIDTH-1:0]                                  uart_rx_data,
  output logic                                                   frame_valid,
  output logic [DATA_WIDTH-1:0]                                  frame_cmd,
  output logic [(FRAME_LENGTH-SYNC_LEN-CRC_LEN-1)*DATA_WIDTH-1:0] frame_payload,
  output logic                                                   crc_error,
  output logic                                                   timeout_error,
  output logic                                                   busy
);

  localparam int BODY_LEN = FRAME_LENGTH - SYNC_LEN - CRC_LEN;
  localparam int BODY_W   = BODY_LEN * DATA_WIDTH;
  localparam int PAY_W    = (BODY_LEN - 1) * DATA_WIDTH;
  localparam int CNT_W    = $clog2(BODY_LEN + 1);
  localparam int IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);

  dfr_state_e                r_state, w_state_next;
  // The 16-bit sync history is {r_prev, current byte}; only the older half
  // needs storage because the match is taken on the strobe cycle itself.
  logic [DATA_WIDTH-1:0]     r_prev;
  logic [BODY_W-1:0]         r_body;
  logic [15:0]               r_crc_rx;
  logic [CNT_W-1:0]          r_cnt;
  logic [IDLE_W-1:0]         r_idle;
  logic                      r_frame_valid, r_crc_error, r_timeout_error;
  logic [DATA_WIDTH-1:0]     r_frame_cmd;
  logic [PAY_W-1:0]          r_frame_payload;

  logic                      w_timeout, w_sync_hit, w_in_frame;
  logic                      w_crc_sync_rst, w_crc_en;
  logic [DATA_WIDTH-1:0]     w_crc_data;
  logic [15:0]               w_crc_out;
  logic                      w_prev_clr, w_body_shift, w_crc_rx_shift;
  logic                      w_cnt_clr, w_cnt_inc, w_load_out;
  logic                      w_fv_next, w_ce_next, w_to_next;

  crc16_CCITT u_crc (
    .clk        (clk),
    .rst_n      (reset_n),
    .sync_reset (w_crc_sync_rst),
    .crc_en     (w_crc_en),
    .data_in    (w_crc_data),
    .crc_out    (w_crc_out)
  );

  assign w_in_frame = (r_state == S_BODY) || (r_state == S_CRC);
  // Timeout has priority over a byte arriving in the same cycle.
  assign w_timeout  = w_in_frame && (r_idle == IDLE_W'(TIMEOUT_CYCLES));
  assign w_sync_hit = uart_rx_valid && ({r_prev, uart_rx_data} == SYNC_WORD);

  always_comb begin
    w_state_next   = r_state;
    w_crc_sync_rst = 1'b0;
    w_crc_en       = 1'b0;
    w_crc_data     = uart_rx_data;
    w_prev_clr     = 1'b0;
    w_body_shift   = 1'b0;
    w_crc_rx_shift = 1'b0;
    w_cnt_clr      = 1'b0;
    w_cnt_inc      = 1'b0;
    w_load_out     = 1'b0;
    w_fv_next      = 1'b0;
    w_ce_next      = 1'b0;
    w_to_next      = 1'b0;
    case (r_state)
      S_HUNT: begin
        w_crc_sync_rst = 1'b1;
        if (w_sync_hit) w_state_next = S_SEED0;
      end
      S_SEED0: begin
        w_crc_en     = 1'b1;
        w_crc_data   = SYNC_WORD[15:8];
        w_state_next = S_SEED1;
      end
      S_SEED1: begin
        w_crc_en     = 1'b1;
        w_crc_data   = SYNC_WORD[7:0];
        w_cnt_clr    = 1'b1;
        w_state_next = S_BODY;
      end
      S_BODY: begin
        if (w_timeout) begin
          w_to_next    = 1'b1;
          w_prev_clr   = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = S_HUNT;
        end else if (uart_rx_valid) begin
          w_body_shift = 1'b1;
          w_crc_en     = 1'b1;
          if (r_cnt == CNT_W'(BODY_LEN - 1)) begin
            w_cnt_clr    = 1'b1;
            w_state_next = S_CRC;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_CRC: begin
        if (w_timeout) begin
          w_to_next    = 1'b1;
          w_prev_clr   = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = S_HUNT;
        end else if (uart_rx_valid) begin
          w_crc_rx_shift = 1'b1;
          if (r_cnt == CNT_W'(CRC_LEN - 1)) begin
            w_cnt_clr    = 1'b1;
            w_state_next = S_CHECK;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (w_crc_out == r_crc_rx) begin
          w_fv_next  = 1'b1;
          w_load_out = 1'b1;
        end else begin
          w_ce_next = 1'b1;
        end
        w_prev_clr     = 1'b1;
        w_crc_sync_rst = 1'b1;
        w_state_next   = S_HUNT;
      end
      default: begin
        w_crc_sync_rst = 1'b1;
        w_state_next   = S_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_HUNT;
      r_prev          <= '0;
      r_body          <= '0;
      r_crc_rx        <= '0;
      r_cnt           <= '0;
      r_idle          <= '0;
      r_frame_valid   <= 1'b0;
      r_crc_error     <= 1'b0;
      r_timeout_error <= 1'b0;
      r_frame_cmd     <= '0;
      r_frame_payload <= '0;
    end else begin
      r_state         <= w_state_next;
      r_frame_valid   <= w_fv_next;
      r_crc_error     <= w_ce_next;
      r_timeout_error <= w_to_next;

      if (w_prev_clr)                               r_prev <= '0;
      else if (r_state == S_HUNT && uart_rx_valid) r_prev <= uart_rx_data;

      if (w_body_shift)   r_body   <= {r_body[BODY_W-DATA_WIDTH-1:0], uart_rx_data};
      if (w_crc_rx_shift) r_crc_rx <= {r_crc_rx[7:0], uart_rx_data};

      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);

      if (uart_rx_valid || w_timeout || !w_in_frame) r_idle <= '0;
      else                                           r_idle <= r_idle + IDLE_W'(1);

      if (w_load_out) begin
        r_frame_cmd     <= r_body[BODY_W-1 -: DATA_WIDTH];
        r_frame_payload <= r_body[PAY_W-1:0];
      end
    end
  end

  assign frame_valid   = r_frame_valid;
  assign crc_error     = r_crc_error;
  assign timeout_error = r_timeout_error;
  assign frame_cmd     = r_frame_cmd;
  assign frame_payload = r_frame_payload;
  assign busy          = (r_state != S_HUNT);

endmodule

// File: tb/tb_debug_frame_rx.sv
// Directed bench for debug_frame_rx: good frame, bad CRC, overlapping sync,
// idle timeout, reset mid-frame and back-to-back frames.
module tb_debug_frame_rx;

  localparam int FL    = 12;
  localparam int DW    = 8;
  localparam int PAY_B = FL - 2 - 2 - 1;
  localparam int PAY_W = PAY_B * DW;
  localparam int TO    = 100;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             uart_rx_valid = 1'b0;
  logic [DW-1:0]    uart_rx_data = '0;
  logic             frame_valid, crc_error, timeout_error, busy;
  logic [DW-1:0]    frame_cmd;
  logic [PAY_W-1:0] frame_payload;

  debug_frame_rx #(
    .DATA_WIDTH     (DW),
    .FRAME_LENGTH   (FL),
    .SYNC_LEN       (2),
    .CRC_LEN        (2),
    .SYNC_WORD      (16'h5AA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .frame_valid   (frame_valid),
    .frame_cmd     (frame_cmd),
    .frame_payload (frame_payload),
    .crc_error     (crc_error),
    .timeout_error (timeout_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_fv  = 0;
  int n_ce  = 0;
  int n_to  = 0;
  int cyc   = 0;
  int last_v = -100;

  always @(negedge clk) begin
    if (frame_valid)   n_fv++;
    if (crc_error)     n_ce++;
    if (timeout_error) n_to++;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_rx_valid) begin
      assert (cyc - last_v >= 4) else $error("uart_rx_valid spacing below 4 clocks");
      last_v <= cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] gold_crc(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  function automatic logic [8*FL-1:0] build_frame(input logic [7:0] cmd,
                                                  input logic [PAY_W-1:0] pay,
                                                  input logic [7:0] crc_xor);
    logic [8*(FL-2)-1:0] body;
    logic [15:0]         c;
    body = {16'h5AA5, cmd, pay};
    c = 16'hFFFF;
    for (int i = 0; i < FL - 2; i++) c = gold_crc(c, body[8*(FL-3-i) +: 8]);
    return {body, c[15:8], c[7:0] ^ crc_xor};
  endfunction

  function automatic logic [7:0] fbyte(input logic [8*FL-1:0] fr, input int i);
    return fr[8*(FL-1-i) +: 8];
  endfunction

  // Returns one negedge after the sampling edge.
  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_byte(b);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input string tag, input logic [8*FL-1:0] fr);
    for (int i = 0; i < FL - 1; i++) begin
      send_byte(fbyte(fr, i));
      if (i == 5) chk({tag, "_busy_mid"}, 64'(busy), 64'd1);
    end
    drive_byte(fbyte(fr, FL - 1));
  endtask

  // Called right after the last byte; strobe expected on the second edge.
  task automatic expect_outcome(input string tag, input logic fv, input logic ce,
                                input logic [7:0] cmd, input logic [PAY_W-1:0] pay);
    chk({tag, "_fv_early"}, 64'(frame_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_fv"},  64'(frame_valid), 64'(fv));
    chk({tag, "_ce"},  64'(crc_error),   64'(ce));
    chk({tag, "_cmd"}, 64'(frame_cmd),   64'(cmd));
    chk({tag, "_pay"}, 64'(frame_payload), 64'(pay));
    @(negedge clk);
    chk({tag, "_strobe_low"}, 64'({frame_valid, crc_error}), 64'd0);
    chk({tag, "_busy_end"},   64'(busy), 64'd0);
  endtask

  initial begin
    logic [8*FL-1:0] fr;
    int fv0, ce0, to0, waited;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fv",   64'(frame_valid),   64'd0);
    chk("rst_ce",   64'(crc_error),     64'd0);
    chk("rst_to",   64'(timeout_error), 64'd0);
    chk("rst_busy", 64'(busy),          64'd0);
    chk("rst_cmd",  64'(frame_cmd),     64'd0);
    chk("rst_pay",  64'(frame_payload), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // good frame
    fv0 = n_fv;
    fr = build_frame(8'h03, 56'h01020304050607, 8'h00);
    send_frame("good", fr);
    expect_outcome("good", 1'b1, 1'b0, 8'h03, 56'h01020304050607);
    chk("good_fv_once", 64'(n_fv - fv0), 64'd1);

    // corrupted CRC, outputs hold
    fv0 = n_fv; ce0 = n_ce;
    fr = build_frame(8'h11, 56'hA1A2A3A4A5A6A7, 8'h01);
    send_frame("badcrc", fr);
    expect_outcome("badcrc", 1'b0, 1'b1, 8'h03, 56'h01020304050607);
    chk("badcrc_ce_once", 64'(n_ce - ce0), 64'd1);
    chk("badcrc_no_fv",   64'(n_fv - fv0), 64'd0);

    // overlapping sync, sync pattern inside payload is plain data
    send_byte(8'h00);
    send_byte(8'h5A);
    fr = build_frame(8'h22, 56'h5AA50C0D0E0F10, 8'h00);
    send_frame("ovl", fr);
    expect_outcome("ovl", 1'b1, 1'b0, 8'h22, 56'h5AA50C0D0E0F10);

    // timeout after sync + 3 body bytes
    to0 = n_to;
    fr = build_frame(8'h33, 56'h11121314151617, 8'h00);
    for (int i = 0; i < 5; i++) send_byte(fbyte(fr, i));
    chk("to_busy", 64'(busy), 64'd1);
    waited = 0;
    while (!timeout_error && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("to_seen",   64'(timeout_error), 64'd1);
    chk("to_window", 64'(waited >= 90 && waited <= 110), 64'd1);
    @(negedge clk);
    #1;
    chk("to_once",      64'(n_to - to0), 64'd1);
    chk("to_busy_end",  64'(busy),       64'd0);
    chk("to_pulse_low", 64'(timeout_error), 64'd0);
    fr = build_frame(8'h44, 56'h21222324252627, 8'h00);
    send_frame("after_to", fr);
    expect_outcome("after_to", 1'b1, 1'b0, 8'h44, 56'h21222324252627);

    // reset mid-frame
    fr = build_frame(8'h77, 56'h31323334353637, 8'h00);
    for (int i = 0; i < 6; i++) send_byte(fbyte(fr, i));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cmd",  64'(frame_cmd),     64'd0);
    chk("mid_rst_pay",  64'(frame_payload), 64'd0);
    chk("mid_rst_busy", 64'(busy),          64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    fv0 = n_fv; ce0 = n_ce; to0 = n_to;
    for (int i = 6; i < FL; i++) send_byte(fbyte(fr, i));
    repeat (5) @(negedge clk);
    chk("stale_no_strobe", 64'((n_fv - fv0) + (n_ce - ce0) + (n_to - to0)), 64'd0);
    fr = build_frame(8'h04, 56'h41424344454647, 8'h00);
    send_frame("after_rst", fr);
    expect_outcome("after_rst", 1'b1, 1'b0, 8'h04, 56'h41424344454647);

    // back-to-back frames at minimum spacing
    fv0 = n_fv;
    fr = build_frame(8'h55, 56'h51525354555657, 8'h00);
    send_frame("b2b_a", fr);
    expect_outcome("b2b_a", 1'b1, 1'b0, 8'h55, 56'h51525354555657);
    fr = build_frame(8'h66, 56'h61626364656667, 8'h00);
    send_frame("b2b_b", fr);
    expect_outcome("b2b_b", 1'b1, 1'b0, 8'h66, 56'h61626364656667);
    #1;
    chk("b2b_two_fv", 64'(n_fv - fv0), 64'd2);
    chk("total_to",   64'(n_to),       64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
